axi_read_slave_mem: RTL and testbench
=====================================

Name: axi_read_slave_mem

Overview:
- AXI-style read-channel responder: one memory-backed slave on an AXI_Interconnect slave port (S0/S1).
- Accepts an AR request, then returns a burst of R beats with RLAST on the final beat.
- Out-of-range and illegal requests get error responses, never hangs.
- A sideband preload port fills the memory before traffic, and serves as the bench's known-data source.

Parameters:
- ADDR_LO, 32'd1, lowest word address this slave decodes (inclusive).
- ADDR_HI, 32'd5, highest word address this slave decodes (inclusive).
- DEPTH, 16, memory words; ADDR_HI-ADDR_LO+1 must be <= DEPTH.
- WAIT_CYCLES, 2, idle cycles inserted before each beat (used only with AXI_RS_WAIT_EN).

Ports:
- G_clk  in  1  clock, rising edge.
- G_reset  in  1  asynchronous active-low reset.
- ARADDR  in  32  word address of first beat.
- ARLEN  in  4  beats-1.
- ARSIZE  in  3  beat size; only 3'b010 legal.
- ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- ARVALID  in  1  request valid.
- ARREADY  out  1  request accept.
- RDATA  out  32  read data.
- RRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- RLAST  out  1  final beat.
- RVALID  out  1  data valid.
- RREADY  in  1  master accepts beat.
- PL_WE  in  1  preload write enable.
- PL_ADDR  in  32  preload word address (absolute).
- PL_WDATA  in  32  preload data.

Behaviour:
- Reset (G_reset=0, async):
  - All outputs 0; state IDLE; beat counter 0.
  - Memory contents are not cleared.
  - Reset mid-burst aborts the burst immediately; no further beats are issued.
- ARREADY timing:
  - Registered, 0 in reset.
  - Goes 1 on the first rising edge after reset release.
  - High only in IDLE.
- States:
  - IDLE: ARREADY=1. On ARVALID&&ARREADY at edge N, capture ARADDR/ARLEN/ARSIZE/ARBURST, drop ARREADY and go to BEAT.
  - BEAT: RVALID=1 from cycle N+1 (one-cycle latency). RDATA/RRESP/RLAST stay stable until RVALID&&RREADY.
  - On each handshake, advance the address and decrement the remaining count.
  - On the handshake with RLAST=1, go to IDLE: RVALID/RLAST drop and ARREADY=1 on the same edge.
  - No overlapped requests.
- Address sequencing per beat:
  - FIXED: address unchanged.
  - INCR: address+1, 32-bit wrap-around.
  - WRAP: the low log2(ARLEN+1) bits increment modulo (ARLEN+1); the upper bits are held.
- Request-level errors: SLVERR on every beat, RDATA=0, still ARLEN+1 beats with a correct RLAST. Triggered by:
  - ARSIZE != 3'b010;
  - ARBURST == 11;
  - WRAP with ARLEN not in {1,3,7,15}.
- Per-beat decode:
  - Beat address outside [ADDR_LO, ADDR_HI]: DECERR, RDATA=0 for that beat only.
  - Otherwise OKAY, RDATA = mem[addr-ADDR_LO].
  - SLVERR takes priority over DECERR.
- RREADY low holds the current beat indefinitely; RREADY high while RVALID=0 has no effect.
- ARVALID while not in IDLE is ignored (ARREADY=0); the master keeps it asserted.
- Preload:
  - PL_WE writes mem[PL_ADDR-ADDR_LO] at the edge; out-of-range PL_ADDR is dropped.
  - Preload has priority for memory access. A beat launched in the same cycle reads the old value.

Optional Feature:
- Macro AXI_RS_WAIT_EN.
- When defined: before each beat, including the first, RVALID stays 0 for WAIT_CYCLES cycles in a WAIT state. A WAIT_CYCLES counter reloads after every beat handshake; the first-beat latency becomes 1+WAIT_CYCLES.
- When undefined: no WAIT state and no counter logic; beats are back-to-back whenever RREADY=1.

Test Plan:
- Single INCR read, in range:
  - Stimulus: preload mem[2]=32'h0000_00A2; then ARADDR=2, ARLEN=0, ARSIZE=010, ARBURST=01.
  - Required: ARREADY=1 at handshake; one cycle later RVALID=1, RDATA=32'hA2, RRESP=00, RLAST=1; RREADY=1 returns the block to IDLE with ARREADY=1.
- INCR burst with backpressure:
  - Stimulus: ARADDR=2, ARLEN=3; RREADY toggles 1,0,1,1,1.
  - Required: beats from addresses 2,3,4,5; the beat on the RREADY=0 cycle is repeated unchanged; RLAST only on the 4th beat.
- Burst crossing the decode range:
  - Stimulus: ARADDR=4, ARLEN=2, INCR.
  - Required: RRESP 00,00,11 for addresses 4,5,6; third RDATA=0; RLAST=1 on the third beat.
- WRAP and illegal requests:
  - Stimulus: ARADDR=3, ARLEN=3, WRAP.
  - Required: addresses 3,0,1,2 → RRESP 00,11,00,00.
  - Stimulus: ARSIZE=111, ARBURST=11, ARLEN=1.
  - Required: 2 beats of SLVERR with RDATA=0.
- Reset mid-burst:
  - Stimulus: ARLEN=7; G_reset=0 after beat 2.
  - Required: RVALID/RLAST/ARREADY go 0 immediately; after release, ARREADY=1 on the next edge and a new ARLEN=0 read completes normally.
- With AXI_RS_WAIT_EN and WAIT_CYCLES=2:
  - Stimulus: ARLEN=1 with RREADY held 1.
  - Required: RVALID rises 3 cycles after the AR handshake, drops for 2 cycles between beats, and RLAST=1 on beat 2.

Source files
------------

// File: rtl/axi_read_slave_mem.sv
// axi_read_slave_mem: AXI read-channel responder backed by a sideband-preloadable word memory.
// Define AXI_RS_WAIT_EN to insert WAIT_CYCLES idle cycles before every beat.

module axi_read_slave_mem #(
  parameter logic [31:0] ADDR_LO = 32'd1,
  parameter logic [31:0] ADDR_HI = 32'd5,
  parameter int          DEPTH   = 16
`ifdef AXI_RS_WAIT_EN
  ,
  parameter int          WAIT_CYCLES = 2
`endif
) (
  input  logic        G_clk,
  input  logic        G_reset,
  input  logic [31:0] ARADDR,
  input  logic [3:0]  ARLEN,
  input  logic [2:0]  ARSIZE,
  input  logic [1:0]  ARBURST,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RLAST,
  output logic        RVALID,
  input  logic        RREADY,
  input  logic        PL_WE,
  input  logic [31:0] PL_ADDR,
  input  logic [31:0] PL_WDATA
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BEAT = 2'd1
`ifdef AXI_RS_WAIT_EN
    ,
    S_WAIT = 2'd2
`endif
  } state_t;

  function automatic logic in_range(input logic [31:0] a);
    return (a >= ADDR_LO) && (a <= ADDR_HI);
  endfunction

  function automatic logic [AW-1:0] mem_idx(input logic [31:0] a);
    logic [31:0] d;
    d = a - ADDR_LO;
    return d[AW-1:0];
  endfunction

  // WRAP holds the upper bits; the low bits covered by len (1/3/7/15) count modulo len+1.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst,
                                            input logic [3:0] len);
    logic [31:0] mask;
    logic [31:0] r;
    mask = {28'd0, len};
    case (burst)
      2'b00:   r = a;
      2'b01:   r = a + 32'd1;
      2'b10:   r = (a & ~mask) | ((a + 32'd1) & mask);
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic req_err(input logic [2:0] size, input logic [1:0] burst,
                                   input logic [3:0] len);
    logic wrap_bad;
    wrap_bad = (burst == 2'b10) &&
               !((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15));
    return (size != 3'b010) || (burst == 2'b11) || wrap_bad;
  endfunction

  state_t      state_r, state_s;
  logic [31:0] addr_r;
  logic [3:0]  rem_r;
  logic [3:0]  len_r;
  logic [1:0]  burst_r;
  logic        err_r;
  logic        arready_r, rvalid_r, rlast_r;
  logic [31:0] rdata_r;
  logic [1:0]  rresp_r;
  logic [31:0] mem_r [DEPTH];

  logic        take_req_s, beat_done_s;
  logic        launch_s, launch_last_s, launch_err_s;
  logic [31:0] launch_addr_s;

`ifdef AXI_RS_WAIT_EN
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  logic [CW-1:0] wait_cnt_r;
`endif

  assign take_req_s  = (state_r == S_IDLE) && arready_r && ARVALID;
  assign beat_done_s = (state_r == S_BEAT) && rvalid_r && RREADY;

  // Next-state and beat-launch decode.
  always_comb begin
    state_s       = state_r;
    launch_s      = 1'b0;
    launch_addr_s = addr_r;
    launch_last_s = (rem_r == 4'd0);
    launch_err_s  = err_r;
    case (state_r)
      S_IDLE: begin
        if (take_req_s) begin
`ifdef AXI_RS_WAIT_EN
          state_s = S_WAIT;
`else
          state_s       = S_BEAT;
          launch_s      = 1'b1;
          launch_addr_s = ARADDR;
          launch_last_s = (ARLEN == 4'd0);
          launch_err_s  = req_err(ARSIZE, ARBURST, ARLEN);
`endif
        end else begin
          state_s = S_IDLE;
        end
      end
      S_BEAT: begin
        if (beat_done_s) begin
          if (rlast_r) begin
            state_s = S_IDLE;
          end else begin
`ifdef AXI_RS_WAIT_EN
            state_s = S_WAIT;
`else
            state_s       = S_BEAT;
            launch_s      = 1'b1;
            launch_addr_s = next_addr(addr_r, burst_r, len_r);
            launch_last_s = (rem_r == 4'd1);
`endif
          end
        end else begin
          state_s = S_BEAT;
        end
      end
`ifdef AXI_RS_WAIT_EN
      S_WAIT: begin
        if (wait_cnt_r == {CW{1'b0}}) begin
          state_s  = S_BEAT;
          launch_s = 1'b1;
        end else begin
          state_s = S_WAIT;
        end
      end
`endif
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge G_clk or negedge G_reset) begin
    if (!G_reset) state_r <= S_IDLE;
    else          state_r <= state_s;
  end

  // Request context: address of the current/pending beat and beats remaining after it.
  always_ff @(posedge G_clk or negedge G_reset) begin
    if (!G_reset) begin
      addr_r  <= 32'd0;
      rem_r   <= 4'd0;
      len_r   <= 4'd0;
      burst_r <= 2'b00;
      err_r   <= 1'b0;
    end else if (take_req_s) begin
      addr_r  <= ARADDR;
      rem_r   <= ARLEN;
      len_r   <= ARLEN;
      burst_r <= ARBURST;
      err_r   <= req_err(ARSIZE, ARBURST, ARLEN);
    end else if (beat_done_s && !rlast_r) begin
      addr_r <= next_addr(addr_r, burst_r, len_r);
      rem_r  <= rem_r - 4'd1;
    end
  end

`ifdef AXI_RS_WAIT_EN
  // Wait-state counter, reloaded whenever another beat becomes pending.
  always_ff @(posedge G_clk or negedge G_reset) begin
    if (!G_reset) begin
      wait_cnt_r <= {CW{1'b0}};
    end else if (take_req_s || (beat_done_s && !rlast_r)) begin
      wait_cnt_r <= CW'(WAIT_CYCLES - 1);
    end else if ((state_r == S_WAIT) && (wait_cnt_r != {CW{1'b0}})) begin
      wait_cnt_r <= wait_cnt_r - CW'(1);
    end
  end
`endif

  // Registered R-channel and ARREADY outputs; SLVERR outranks DECERR.
  always_ff @(posedge G_clk or negedge G_reset) begin
    if (!G_reset) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rdata_r   <= 32'd0;
      rresp_r   <= 2'b00;
    end else begin
      arready_r <= (state_s == S_IDLE);
      if (launch_s) begin
        rvalid_r <= 1'b1;
        rlast_r  <= launch_last_s;
        if (launch_err_s) begin
          rresp_r <= 2'b10;
          rdata_r <= 32'd0;
        end else if (!in_range(launch_addr_s)) begin
          rresp_r <= 2'b11;
          rdata_r <= 32'd0;
        end else begin
          rresp_r <= 2'b00;
          rdata_r <= mem_r[mem_idx(launch_addr_s)];
        end
      end else if (beat_done_s) begin
        rvalid_r <= 1'b0;
        rlast_r  <= 1'b0;
        rresp_r  <= 2'b00;
        rdata_r  <= 32'd0;
      end
    end
  end

  // Preload port; contents survive reset, a same-edge beat launch sees the old word.
  always_ff @(posedge G_clk) begin
    if (PL_WE && in_range(PL_ADDR)) begin
      mem_r[mem_idx(PL_ADDR)] <= PL_WDATA;
    end
  end

  assign ARREADY = arready_r;
  assign RVALID  = rvalid_r;
  assign RLAST   = rlast_r;
  assign RDATA   = rdata_r;
  assign RRESP   = rresp_r;

endmodule

// File: tb/tb_axi_read_slave_mem.sv
// Directed self-checking bench for axi_read_slave_mem (default parameters, either build).

module tb_axi_read_slave_mem;

`ifdef AXI_RS_WAIT_EN
  localparam int LAT = 2;
  localparam int GAP = 2;
`else
  localparam int LAT = 0;
  localparam int GAP = 0;
`endif

  logic        G_clk = 1'b0;
  logic        G_reset = 1'b0;
  logic [31:0] ARADDR = 32'd0;
  logic [3:0]  ARLEN = 4'd0;
  logic [2:0]  ARSIZE = 3'b010;
  logic [1:0]  ARBURST = 2'b01;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic        PL_WE = 1'b0;
  logic [31:0] PL_ADDR = 32'd0;
  logic [31:0] PL_WDATA = 32'd0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] obs_data[$];
  logic [1:0]  obs_resp[$];
  logic        obs_last[$];
  int          obs_cyc[$];
  logic        timed_out;
  logic        ar_seen;

  axi_read_slave_mem dut (
    .G_clk(G_clk), .G_reset(G_reset),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .PL_WE(PL_WE), .PL_ADDR(PL_ADDR), .PL_WDATA(PL_WDATA)
  );

  always #5 G_clk = ~G_clk;

  task automatic tick();
    @(posedge G_clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    PL_WE = 1'b1; PL_ADDR = a; PL_WDATA = d;
    tick();
    PL_WE = 1'b0;
  endtask

  task automatic start_req(input logic [31:0] a, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    int k;
    k = 0;
    while (ARREADY !== 1'b1 && k < 20) begin tick(); k++; end
    ar_seen = ARREADY;
    ARADDR = a; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
  endtask

  // Records every cycle with RVALID=1; pat[i] is RREADY on the i-th such cycle.
  task automatic collect(input logic [7:0] pat);
    int step;
    logic done;
    logic rr;
    obs_data.delete(); obs_resp.delete(); obs_last.delete(); obs_cyc.delete();
    step = 0; done = 1'b0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (RVALID === 1'b1) begin
        rr = (step < 8) ? pat[step] : 1'b1;
        obs_data.push_back(RDATA); obs_resp.push_back(RRESP);
        obs_last.push_back(RLAST); obs_cyc.push_back(cyc);
        if (rr && RLAST === 1'b1) done = 1'b1;
        step++;
        RREADY = rr;
      end else begin
        RREADY = 1'b1;
      end
      tick();
    end
    RREADY = 1'b0;
    timed_out = !done;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_tests++; if (ARREADY !== 1'b0) begin n_fail++; $display("FAIL reset_arready: got %b want 0", ARREADY); end
    n_tests++; if (RVALID !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", RVALID); end
    n_tests++; if (RLAST !== 1'b0) begin n_fail++; $display("FAIL reset_rlast: got %b want 0", RLAST); end
    n_tests++; if (RDATA !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", RDATA); end
    n_tests++; if (RRESP !== 2'b00) begin n_fail++; $display("FAIL reset_rresp: got %b want 00", RRESP); end
    G_reset = 1'b1;
    tick();
    n_tests++; if (ARREADY !== 1'b1) begin n_fail++; $display("FAIL release_arready: got %b want 1", ARREADY); end
  endtask

  task automatic test_single();
    start_req(32'd2, 4'd0, 3'b010, 2'b01);
    n_tests++; if (ar_seen !== 1'b1) begin n_fail++; $display("FAIL single_arready_hs: got %b want 1", ar_seen); end
    n_tests++; if (ARREADY !== 1'b0) begin n_fail++; $display("FAIL single_arready_busy: got %b want 0", ARREADY); end
    collect(8'hFF);
    n_tests++; if (timed_out || obs_data.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d beats timeout=%b want 1", obs_data.size(), timed_out); end
    if (obs_data.size() >= 1) begin
      n_tests++; if (obs_cyc[0] != LAT) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", obs_cyc[0], LAT); end
      n_tests++; if (obs_data[0] !== 32'h0000_00A2) begin n_fail++; $display("FAIL single_rdata: got %h want 000000a2", obs_data[0]); end
      n_tests++; if (obs_resp[0] !== 2'b00) begin n_fail++; $display("FAIL single_rresp: got %b want 00", obs_resp[0]); end
      n_tests++; if (obs_last[0] !== 1'b1) begin n_fail++; $display("FAIL single_rlast: got %b want 1", obs_last[0]); end
    end
    n_tests++; if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin n_fail++; $display("FAIL single_idle: got arready=%b rvalid=%b want 1 0", ARREADY, RVALID); end
  endtask

  task automatic test_backpressure();
    logic [31:0] ed [5];
    logic        el [5];
    ed = '{32'hA2, 32'hA3, 32'hA3, 32'hA4, 32'hA5};
    el = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    start_req(32'd2, 4'd3, 3'b010, 2'b01);
    collect(8'b1111_1101);
    n_tests++; if (timed_out || obs_data.size() != 5) begin n_fail++; $display("FAIL bp_count: got %0d timeout=%b want 5", obs_data.size(), timed_out); end
    for (int i = 0; i < 5 && i < obs_data.size(); i++) begin
      n_tests++;
      if (obs_data[i] !== ed[i] || obs_last[i] !== el[i] || obs_resp[i] !== 2'b00) begin
        n_fail++; $display("FAIL bp_beat%0d: got %h/%b/%b want %h/00/%b", i, obs_data[i], obs_resp[i], obs_last[i], ed[i], el[i]);
      end
    end
    n_tests++; if (ARREADY !== 1'b1) begin n_fail++; $display("FAIL bp_idle: got arready=%b want 1", ARREADY); end
  endtask

  task automatic test_crossing();
    logic [31:0] ed [3];
    logic [1:0]  er [3];
    ed = '{32'hA4, 32'hA5, 32'h0};
    er = '{2'b00, 2'b00, 2'b11};
    start_req(32'd4, 4'd2, 3'b010, 2'b01);
    collect(8'hFF);
    n_tests++; if (timed_out || obs_data.size() != 3) begin n_fail++; $display("FAIL cross_count: got %0d timeout=%b want 3", obs_data.size(), timed_out); end
    for (int i = 0; i < 3 && i < obs_data.size(); i++) begin
      n_tests++;
      if (obs_data[i] !== ed[i] || obs_resp[i] !== er[i] || obs_last[i] !== (i == 2)) begin
        n_fail++; $display("FAIL cross_beat%0d: got %h/%b/%b want %h/%b/%b", i, obs_data[i], obs_resp[i], obs_last[i], ed[i], er[i], (i == 2));
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ed [4];
    logic [1:0]  er [4];
    ed = '{32'hA3, 32'h0, 32'hA1, 32'hA2};
    er = '{2'b00, 2'b11, 2'b00, 2'b00};
    start_req(32'd3, 4'd3, 3'b010, 2'b10);
    collect(8'hFF);
    n_tests++; if (timed_out || obs_data.size() != 4) begin n_fail++; $display("FAIL wrap_count: got %0d timeout=%b want 4", obs_data.size(), timed_out); end
    for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
      n_tests++;
      if (obs_data[i] !== ed[i] || obs_resp[i] !== er[i] || obs_last[i] !== (i == 3)) begin
        n_fail++; $display("FAIL wrap_beat%0d: got %h/%b/%b want %h/%b/%b", i, obs_data[i], obs_resp[i], obs_last[i], ed[i], er[i], (i == 3));
      end
    end
  endtask

  task automatic test_illegal();
    start_req(32'd2, 4'd1, 3'b111, 2'b11);
    collect(8'hFF);
    n_tests++; if (timed_out || obs_data.size() != 2) begin n_fail++; $display("FAIL illegal_count: got %0d timeout=%b want 2", obs_data.size(), timed_out); end
    for (int i = 0; i < 2 && i < obs_data.size(); i++) begin
      n_tests++;
      if (obs_data[i] !== 32'd0 || obs_resp[i] !== 2'b10 || obs_last[i] !== (i == 1)) begin
        n_fail++; $display("FAIL illegal_beat%0d: got %h/%b/%b want 0/10/%b", i, obs_data[i], obs_resp[i], obs_last[i], (i == 1));
      end
    end
    start_req(32'd2, 4'd2, 3'b010, 2'b10);
    collect(8'hFF);
    n_tests++; if (timed_out || obs_data.size() != 3) begin n_fail++; $display("FAIL wraplen_count: got %0d timeout=%b want 3", obs_data.size(), timed_out); end
    for (int i = 0; i < 3 && i < obs_data.size(); i++) begin
      n_tests++;
      if (obs_data[i] !== 32'd0 || obs_resp[i] !== 2'b10 || obs_last[i] !== (i == 2)) begin
        n_fail++; $display("FAIL wraplen_beat%0d: got %h/%b/%b want 0/10/%b", i, obs_data[i], obs_resp[i], obs_last[i], (i == 2));
      end
    end
  endtask

  task automatic test_fixed();
    start_req(32'd5, 4'd2, 3'b010, 2'b00);
    collect(8'hFF);
    n_tests++; if (timed_out || obs_data.size() != 3) begin n_fail++; $display("FAIL fixed_count: got %0d timeout=%b want 3", obs_data.size(), timed_out); end
    for (int i = 0; i < 3 && i < obs_data.size(); i++) begin
      n_tests++;
      if (obs_data[i] !== 32'hA5 || obs_resp[i] !== 2'b00 || obs_last[i] !== (i == 2)) begin
        n_fail++; $display("FAIL fixed_beat%0d: got %h/%b/%b want 000000a5/00/%b", i, obs_data[i], obs_resp[i], obs_last[i], (i == 2));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    start_req(32'd1, 4'd4, 3'b010, 2'b01);
    collect(8'hFF);
    n_tests++; if (timed_out || obs_data.size() != 5) begin n_fail++; $display("FAIL b2b_count: got %0d timeout=%b want 5", obs_data.size(), timed_out); end
    for (int i = 0; i < 5 && i < obs_data.size(); i++) begin
      exp_d = 32'hA1 + 32'(i);
      n_tests++;
      if (obs_data[i] !== exp_d || obs_last[i] !== (i == 4) || obs_cyc[i] != LAT + i * (1 + GAP)) begin
        n_fail++; $display("FAIL b2b_beat%0d: got %h/%b cyc%0d want %h/%b cyc%0d", i, obs_data[i], obs_last[i], obs_cyc[i], exp_d, (i == 4), LAT + i * (1 + GAP));
      end
    end
  endtask

  task automatic test_preload_oor();
    preload(32'd17, 32'hDEAD_0017);
    preload(32'd0, 32'hDEAD_0000);
    start_req(32'd1, 4'd0, 3'b010, 2'b01);
    collect(8'hFF);
    n_tests++;
    if (timed_out || obs_data.size() != 1 || obs_data[0] !== 32'hA1) begin
      n_fail++; $display("FAIL preload_oor: got %0d beats data %h want 1 beat 000000a1", obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : 32'hX);
    end
  endtask

`ifdef AXI_RS_WAIT_EN
  task automatic test_wait();
    start_req(32'd1, 4'd1, 3'b010, 2'b01);
    collect(8'hFF);
    n_tests++; if (timed_out || obs_data.size() != 2) begin n_fail++; $display("FAIL wait_count: got %0d timeout=%b want 2", obs_data.size(), timed_out); end
    if (obs_data.size() == 2) begin
      n_tests++; if (obs_cyc[0] != 2 || obs_cyc[1] != 5) begin n_fail++; $display("FAIL wait_timing: got cyc %0d,%0d want 2,5", obs_cyc[0], obs_cyc[1]); end
      n_tests++; if (obs_last[0] !== 1'b0 || obs_last[1] !== 1'b1 || obs_data[1] !== 32'hA2) begin n_fail++; $display("FAIL wait_beats: got last %b%b data %h want 01 000000a2", obs_last[0], obs_last[1], obs_data[1]); end
    end
  endtask
`else
  task automatic test_preload_collision();
    PL_WE = 1'b1; PL_ADDR = 32'd2; PL_WDATA = 32'h0000_00B2;
    start_req(32'd2, 4'd0, 3'b010, 2'b01);
    PL_WE = 1'b0;
    collect(8'hFF);
    n_tests++; if (timed_out || obs_data.size() != 1 || obs_data[0] !== 32'hA2) begin n_fail++; $display("FAIL collide_old: got %0d beats data %h want 000000a2", obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : 32'hX); end
    start_req(32'd2, 4'd0, 3'b010, 2'b01);
    collect(8'hFF);
    n_tests++; if (timed_out || obs_data.size() != 1 || obs_data[0] !== 32'hB2) begin n_fail++; $display("FAIL collide_new: got %0d beats data %h want 000000b2", obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : 32'hX); end
  endtask
`endif

  task automatic test_reset_mid_burst();
    int k;
    logic any_valid;
    start_req(32'd1, 4'd7, 3'b010, 2'b01);
    for (int b = 0; b < 2; b++) begin
      k = 0;
      while (RVALID !== 1'b1 && k < 20) begin tick(); k++; end
      RREADY = 1'b1; tick(); RREADY = 1'b0;
    end
    G_reset = 1'b0;
    #1;
    n_tests++;
    if (RVALID !== 1'b0 || RLAST !== 1'b0 || ARREADY !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: got rvalid=%b rlast=%b arready=%b want 0 0 0", RVALID, RLAST, ARREADY);
    end
    any_valid = 1'b0;
    RREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); if (RVALID !== 1'b0) any_valid = 1'b1; end
    RREADY = 1'b0;
    n_tests++; if (any_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_quiet: got rvalid seen=%b want 0", any_valid); end
    G_reset = 1'b1;
    n_tests++; if (ARREADY !== 1'b0) begin n_fail++; $display("FAIL midrst_release0: got %b want 0", ARREADY); end
    tick();
    n_tests++; if (ARREADY !== 1'b1) begin n_fail++; $display("FAIL midrst_release1: got %b want 1", ARREADY); end
    start_req(32'd5, 4'd0, 3'b010, 2'b01);
    collect(8'hFF);
    n_tests++;
    if (timed_out || obs_data.size() != 1 || obs_data[0] !== 32'hA5 || obs_resp[0] !== 2'b00 || obs_last[0] !== 1'b1) begin
      n_fail++; $display("FAIL midrst_read: got %0d beats data %h want 1 beat 000000a5 okay last", obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : 32'hX);
    end
  endtask

  initial begin
    test_reset();
    for (int a = 1; a <= 5; a++) preload(32'(a), 32'hA0 + 32'(a));
    test_single();
    test_backpressure();
    test_crossing();
    test_wrap();
    test_illegal();
    test_fixed();
    test_back_to_back();
    test_preload_oor();
`ifdef AXI_RS_WAIT_EN
    test_wait();
`else
    test_preload_collision();
`endif
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
